// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressed little-endian data memory with fixed latency and valid/ready channels
module data_mem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_address,
  input  logic [3:0]  req_xfer_size,
  input  logic [63:0] req_write_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_read_data,
  output logic        rsp_error,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, size_q, size_d;
  logic wr_q, wr_d, err_q, err_d, bad, commit;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, load_data;
  logic [7:0] mem [DEPTH_BYTES];
  assign bad = !(size_q inside {4'd1, 4'd2, 4'd4, 4'd8}) || |(addr_q[2:0] & 3'(size_q - 4'd1)) ||
               |addr_q[63:AW] || (addr_q + 64'(size_q) > 64'(DEPTH_BYTES));
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_read_data = rdata_q;
  assign rsp_error = err_q;
  always_comb begin
    load_data = '0;
    for (int k = 0; k < 8; k++)
      load_data[8*k +: 8] = (4'(k) < size_q) ? mem[addr_q[AW-1:0] + AW'(k)] : 8'h00;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    size_d = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    commit = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = WAIT;
        cnt_d = 4'(LATENCY - 1);
        wr_d = req_write;
        addr_d = req_address;
        size_d = req_xfer_size;
        wdata_d = req_write_data;
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        err_d = bad;
        rdata_d = (bad || wr_q) ? 64'h0 : load_data;
        commit = wr_q && !bad;
      end else cnt_d = cnt_q - 4'd1;
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rdata_d = '0;
        err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      size_q <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  // storage is deliberately outside the reset domain
  always_ff @(posedge clk)
    if (commit)
      for (int k = 0; k < 8; k++)
        if (4'(k) < size_q) mem[addr_q[AW-1:0] + AW'(k)] <= wdata_q[8*k +: 8];
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the processor's MEM-stage data port. It serves load/store requests through a valid/ready request channel and a valid/ready response channel, with a fixed programmable access latency. Storage is a byte-addressed little-endian array. The block lets the pipeline be tested against a multi-cycle memory in place of the single-cycle data memory, and later backs a stall-capable MEM stage.

Parameters:
DEPTH_BYTES, 1024, size of byte storage; must be a power of two and at least 8.
LATENCY, 3, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store, 0 = load.
req_address  input  64  byte address.
req_xfer_size  input  4  bytes to transfer; legal values 1, 2, 4, 8.
req_write_data  input  64  store data; only the low xfer_size bytes are used.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_read_data  output  64  load data, zero-extended; 0 for stores and errors.
rsp_error  output  1  request was rejected: misaligned, out of range, or illegal size.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock, reset and polarity are decided: one clock, clk; reset is asynchronous and active-high, named reset.
- FSM states are IDLE, WAIT and RESP.
- Reset (async) forces IDLE, the latency counter to 0, req_ready=1, rsp_valid=0, rsp_read_data=0, rsp_error=0, busy=0. Storage contents are not reset.
- req_ready is 1 only in IDLE.
- Accept: in IDLE, when req_valid=1, register write, address, size and data, then go to WAIT with counter=LATENCY-1.
- WAIT: decrement the counter each cycle. When the counter is 0, go to RESP on the next edge. With LATENCY=1, WAIT lasts one cycle.
- Result: rsp_valid is first high exactly LATENCY cycles after the accept edge.
- Error check (on captured fields):
  - size not in {1,2,4,8};
  - address[2:0] not a multiple of size;
  - address+size > DEPTH_BYTES;
  - any upper address bits set beyond the DEPTH range.
- On error: rsp_error=1, rsp_read_data=0, and storage is not modified.
- Store commit happens on the WAIT->RESP edge: bytes address..address+size-1 take req_write_data[8*size-1:0], little-endian, with byte k taken from bits [8k+7:8k].
- Load data is sampled on the WAIT->RESP edge. It holds bytes address..address+size-1 little-endian in the low bits, with the upper bits 0.
- RESP:
  - rsp_valid=1, and rsp_read_data and rsp_error stay stable until rsp_ready=1.
  - On handshake, return to IDLE and clear rsp_valid.
  - A new request can be accepted the cycle after the handshake.
- Back-to-back throughput is one request per LATENCY+2 cycles when rsp_ready is held high.
- Reset asserted during WAIT or RESP aborts the transaction. A pending store is not committed. No response is produced after reset deasserts.
- req_* inputs outside IDLE are ignored, and the requester must hold them until accepted.
- rsp_ready while rsp_valid=0 is ignored.

Test Plan:
1. Store then load, with LATENCY=3: store addr 0x10, size 8, data 0x1122334455667788, then load addr 0x10, size 8. Required: rsp_valid 3 cycles after each accept; the load returns 0x1122334455667788 with rsp_error=0.
2. Byte and halfword ops: store byte 0xAB at 0x21, then load size 1 at 0x21 -> 0x00000000000000AB. Load size 2 at 0x20 -> 0x000000000000AB88, assuming 0x20 previously held 0x88.
3. Errors:
   - load size 4 at addr 0x22 -> rsp_error=1, data 0;
   - store size 8 at DEPTH_BYTES-4 -> rsp_error=1, and a following load confirms memory is unchanged;
   - size 3 -> rsp_error=1.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid and data stay stable and req_ready=0; on release, return to IDLE the next cycle.
5. Reset mid-store: store 0xFF at 0x30 (which held 0x00) and assert reset during WAIT. Required: all outputs go to reset values immediately; after release, a load at 0x30 returns 0.
6. LATENCY=1 with rsp_ready tied high: issue 4 consecutive loads. Required: each rsp_valid comes 1 cycle after its accept, and accepts are spaced 3 cycles apart.
